// File: rtl/dffram.sv
// dffram: single-port word RAM with per-byte write enables and a
// registered read port, used as instruction closely-coupled memory.
//
// Build option: define DFFRAM_WRITE_THROUGH_EN to make a same-edge
// write and read of one address return the merged word (written bytes
// from Di, the rest from the old contents). Without it the port is
// read-first and returns the pre-write word.
//
// The storage array is named mem with shape [0:2**AW-1] so that a
// testbench can preload it hierarchically. It is never reset, so
// preloaded contents survive any reset pulse.
module dffram #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            EN,
    input  logic [DW/8-1:0] WE,
    input  logic [AW-1:0]   A,
    input  logic [DW-1:0]   Di,
    output logic [DW-1:0]   Do
);

    localparam int NB = DW / 8;

    logic [DW-1:0] mem [0:2**AW-1];
    logic [DW-1:0] old_word;
    logic [DW-1:0] rd_word;

    // Replace the enabled byte lanes of a stored word with new data.
    function automatic logic [DW-1:0] merge_bytes(
        input logic [DW-1:0] cur,
        input logic [DW-1:0] wdata,
        input logic [NB-1:0] be
    );
        logic [DW-1:0] res;
        res = cur;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign old_word = mem[A];

    // Select what the read port captures on an enabled edge.
`ifdef DFFRAM_WRITE_THROUGH_EN
    always_comb begin
        rd_word = merge_bytes(old_word, Di, WE);
    end
`else
    always_comb begin
        rd_word = old_word;
    end
`endif

    // Byte-masked write into the array; storage has no reset on purpose.
    always_ff @(posedge clk_i) begin
        if (EN) begin
            for (int i = 0; i < NB; i++) begin
                if (WE[i]) begin
                    mem[A][8*i +: 8] <= Di[8*i +: 8];
                end
            end
        end
    end

    // Registered read data: cleared asynchronously, held while disabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            Do <= '0;
        end else if (EN) begin
            Do <= rd_word;
        end
    end

endmodule

// File: tb/tb_dffram.sv
// tb_dffram: directed test of dffram. The stimulus process pushes the
// expected Do for every cycle it wants checked; a monitor pops and
// compares one time unit after each rising edge.
module tb_dffram;

    localparam int AW = 8;
    localparam int DW = 32;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            EN = 1'b0;
    logic [DW/8-1:0] WE = '0;
    logic [AW-1:0]   A = '0;
    logic [DW-1:0]   Di = '0;
    logic [DW-1:0]   Do;

    int checks = 0;
    int passed = 0;

    logic          chk = 1'b0;
    logic [DW-1:0] exp_q [$];
    string         name_q [$];

    dffram #(.AW(AW), .DW(DW)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .EN    (EN),
        .WE    (WE),
        .A     (A),
        .Di    (Di),
        .Do    (Do)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: an access tagged at this edge has its result on Do just after it.
    always @(posedge clk_i) begin
        logic tag;
        tag = chk;
        #1;
        if (tag) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL scoreboard_underflow: got output with no expected value at %0t", $time);
            end else begin
                check(name_q.pop_front(), Do, exp_q.pop_front());
            end
        end
    end

    // Drive one cycle of inputs (called at a falling edge) and optionally
    // queue the value Do must show after the coming rising edge.
    task automatic issue(input logic en, input logic [3:0] we, input logic [7:0] a,
                         input logic [31:0] di, input logic do_chk,
                         input logic [31:0] exp, input string nm);
        EN = en;
        WE = we;
        A  = a;
        Di = di;
        chk = do_chk;
        if (do_chk) begin
            exp_q.push_back(exp);
            name_q.push_back(nm);
        end
        @(negedge clk_i);
    endtask

    initial begin
        logic [31:0] exp_rw;
        logic [31:0] exp_bw;

        // Preload contents; reset must not disturb these.
        dut.mem[0] = 32'h00000093;
        dut.mem[1] = 32'h00100113;
        dut.mem[2] = 32'h00208193;
        dut.mem[3] = 32'h0000006F;
        dut.mem[5] = 32'hAABBCCDD;
        dut.mem[7] = 32'h00000000;

        // Reset held for 10 time units, spanning a rising edge with EN=1.
        EN = 1'b1;
        #2;
        check("reset_do_early", Do, 32'h0);
        #6;
        check("reset_do_after_edge", Do, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        check("reset_release_before_edge", Do, 32'h0);

        // Sequential reads, one per cycle.
        issue(1'b1, 4'b0000, 8'd0, 32'h0, 1'b1, 32'h00000093, "seq_rd0");
        issue(1'b1, 4'b0000, 8'd1, 32'h0, 1'b1, 32'h00100113, "seq_rd1");
        issue(1'b1, 4'b0000, 8'd2, 32'h0, 1'b1, 32'h00208193, "seq_rd2");
        issue(1'b1, 4'b0000, 8'd3, 32'h0, 1'b1, 32'h0000006F, "seq_rd3");

        // Mid-run reset pulse between edges: Do clears without a clock.
        EN  = 1'b0;
        chk = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("midrun_reset_async", Do, 32'h0);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("midrun_reset_hold_disabled", Do, 32'h0);
        issue(1'b1, 4'b0000, 8'd1, 32'h0, 1'b1, 32'h00100113, "contents_after_reset");

        // Byte-masked write to address 5.
`ifdef DFFRAM_WRITE_THROUGH_EN
        exp_bw = 32'hAA22CC44;
        exp_rw = 32'hDEADBEEF;
`else
        exp_bw = 32'hAABBCCDD;
        exp_rw = 32'h00000000;
`endif
        issue(1'b1, 4'b0101, 8'd5, 32'h11223344, 1'b1, exp_bw, "byte_write_same_edge");
        issue(1'b1, 4'b0000, 8'd5, 32'h0, 1'b1, 32'hAA22CC44, "byte_write_readback");

        // Full-word write with same-edge read of address 7.
        issue(1'b1, 4'b1111, 8'd7, 32'hDEADBEEF, 1'b1, exp_rw, "rw_same_addr");
        issue(1'b1, 4'b0000, 8'd7, 32'h0, 1'b1, 32'hDEADBEEF, "rw_readback");

        // Disabled port: no write, Do holds.
        issue(1'b0, 4'b1111, 8'd0, 32'hFFFFFFFF, 1'b1, 32'hDEADBEEF, "en0_do_hold");
        check("en0_mem0_kept", dut.mem[0], 32'h00000093);
        issue(1'b1, 4'b0000, 8'd0, 32'h0, 1'b1, 32'h00000093, "en0_readback");

        // Other addresses untouched by the writes above.
        issue(1'b1, 4'b0000, 8'd3, 32'h0, 1'b1, 32'h0000006F, "neighbour_rd3");

        // Drain and confirm every queued expectation was consumed.
        issue(1'b0, 4'b0000, 8'd0, 32'h0, 1'b0, 32'h0, "");
        repeat (2) @(negedge clk_i);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
